fpu_mul_pipe: RTL and testbench
===============================

FPU_MUL_PIPE -- requirements
Module: fpu_mul_pipe

Interface
REQ-001 Parameter: BIT_WIDTH, default 32, IEEE-754 operand width; legal values 32 or 64.
REQ-002 Parameter: TAG_WIDTH, default 4, width of the sideband tag carried with each operation.
REQ-003 Derived parameters EXP_WIDTH (8/11), SGN_WIDTH (24/53) and BIAS SHALL be computed from BIT_WIDTH and SHALL NOT be overridden.
REQ-004 i_clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 i_reset  in  1  reset, synchronous, active-high.
REQ-006 i_valid  in  1  operation present on the input bus.
REQ-007 o_ready  out  1  block accepts the operation this cycle.
REQ-008 i_mode  in  3  rounding mode: 0 RNE, 1 RNA (ties away), 2 RTP, 3 RTN, 4 RTZ; codes 5-7 SHALL act as RNE.
REQ-009 i_inputA / i_inputB  in  BIT_WIDTH  operands.
REQ-010 i_tag  in  TAG_WIDTH  sideband tag, returned unchanged with the result.
REQ-011 o_valid  out  1  result present on the output bus.
REQ-012 i_ready  in  1  downstream accepts the result.
REQ-013 o_output  out  BIT_WIDTH  product.
REQ-014 o_tag  out  TAG_WIDTH  tag of this result.
REQ-015 o_flags  out  4  {invalid, overflow, underflow, inexact}.

Function
REQ-016 Transfer SHALL occur on a cycle where valid and ready are both high; i_mode, operands and tag SHALL be sampled on the same transfer.
REQ-017 Pipeline: S1 unpack/classify/multiply; S2 normalise/sticky/exponent; S3 round/pack/flags. Latency SHALL be exactly 3 cycles from input transfer to o_valid when there is no backpressure.
REQ-018 Stall: advance = ~o_valid | i_ready; o_ready SHALL equal advance. All stages SHALL hold when advance is low.
REQ-019 Bubbles SHALL NOT be collapsed. With i_ready held high, throughput SHALL be 1 operation per cycle.
REQ-020 Results SHALL emerge in issue order. None SHALL be dropped or duplicated under any i_ready pattern.
REQ-021 o_output, o_tag and o_flags SHALL stay stable while o_valid=1 and i_ready=0.
REQ-022 Result sign SHALL be signA XOR signB for all non-NaN results.
REQ-023 Subnormal inputs SHALL be treated as signed zero (DAZ). This SHALL NOT raise a flag.
REQ-024 NaN handling: any NaN input, or inf x zero, SHALL produce canonical qNaN (sign 0, exponent all-ones, mantissa MSB only). invalid SHALL be set for inf x zero or any signalling NaN input.
REQ-025 Infinity: inf x finite-nonzero SHALL produce correctly signed inf with no flags. Zero x finite SHALL produce signed zero with no flags.
REQ-026 Rounding SHALL use guard bit plus a sticky bit formed as the OR of all remaining product bits. A rounding carry-out SHALL renormalise and increment the exponent.
REQ-027 Rounding rules: RTP increments magnitude of positive results only when inexact. RTN increments magnitude of negative results only when inexact. RTZ truncates. RNA rounds ties away from zero.
REQ-028 Overflow (biased exponent >= all-ones after rounding) SHALL set overflow and inexact. Result: inf for RNE/RNA; max finite for RTZ; +inf or -max for RTP by sign; -inf or +max for RTN by sign.
REQ-029 Underflow (biased exponent < 1 after rounding) SHALL flush to signed zero (FTZ) and set underflow and inexact.
REQ-030 inexact SHALL be set whenever guard|sticky is nonzero for a finite result.

Reset
REQ-031 While i_reset is high: all stage valids, o_valid, o_output, o_tag and o_flags SHALL be 0, and o_ready SHALL be 1 on the first cycle after reset deasserts.
REQ-032 Reset mid-operation SHALL discard all in-flight operations. No result SHALL appear after reset releases unless new input is transferred.

Structure
REQ-033 A shared package fpu_pkg SHALL hold the rounding-mode constants, flag bit indices, and the width/bias derivation functions.
REQ-034 The S3 round/pack logic SHALL be the single sub-module fpu_round_pack, reusable by other FPU pipelines.

Verification
REQ-035 RNE, 0x40000000 x 0x40400000, tag 5 -> 0x40C00000, o_tag 5, flags 0, o_valid exactly 3 cycles after transfer.
REQ-036 0x3F800001 x 0x3F800001 -> 0x3F800002 under RNE and RTZ, 0x3F800003 under RTP, inexact=1 in all three.
REQ-037 0x7F000000 x 0x7F000000 -> RNE 0x7F800000, RTZ 0x7F7FFFFF, flags overflow+inexact. 0x7F800000 x 0x00000000 -> 0x7FC00000, invalid.
REQ-038 0x00800000 x 0x3F000000 -> 0x00000000, flags underflow+inexact. Subnormal 0x00000001 x 0x40000000 -> 0x00000000, flags 0.
REQ-039 Issue 6 back-to-back ops with i_ready low for 5 cycles from cycle 4 -> o_ready low while stalled, all 6 results delivered in order with correct tags, outputs stable during the stall.
REQ-040 Assert i_reset with 3 ops in flight -> o_valid 0 next cycle, no stale result afterwards. Repeat REQ-035 with BIT_WIDTH=64: 0x4000000000000000 x 0x4008000000000000 -> 0x4018000000000000.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding-mode codes, flag bit positions and
// IEEE-754 format derivation helpers.
package fpu_pkg;

  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RNA = 3'd1;
  localparam logic [2:0] RM_RTP = 3'd2;
  localparam logic [2:0] RM_RTN = 3'd3;
  localparam logic [2:0] RM_RTZ = 3'd4;

  localparam int unsigned FLAG_WIDTH     = 4;
  localparam logic [1:0]  FLAG_INVALID   = 2'd3;
  localparam logic [1:0]  FLAG_OVERFLOW  = 2'd2;
  localparam logic [1:0]  FLAG_UNDERFLOW = 2'd1;
  localparam logic [1:0]  FLAG_INEXACT   = 2'd0;

  function automatic int unsigned exp_width(input int unsigned bit_width);
    return (bit_width == 64) ? 32'd11 : 32'd8;
  endfunction

  function automatic int unsigned sgn_width(input int unsigned bit_width);
    return (bit_width == 64) ? 32'd53 : 32'd24;
  endfunction

  function automatic int unsigned exp_bias(input int unsigned bit_width);
    return (32'd1 << (exp_width(bit_width) - 32'd1)) - 32'd1;
  endfunction

endpackage

// File: rtl/fpu_round_pack.sv
// Round, range-check and pack a normalised significand into an IEEE-754 word.
// Purely combinational so any FPU pipeline can register it as its last stage.
module fpu_round_pack
  import fpu_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = 32,
  localparam int unsigned EW = exp_width(BIT_WIDTH),
  localparam int unsigned SW = sgn_width(BIT_WIDTH),
  localparam int unsigned MW = SW - 1
) (
  input  logic                   i_sign,
  input  logic signed [EW+1:0]   i_exp,
  input  logic [MW-1:0]          i_mant,
  input  logic                   i_guard,
  input  logic                   i_sticky,
  input  logic [2:0]             i_mode,
  input  logic                   i_special,
  input  logic [BIT_WIDTH-1:0]   i_special_val,
  input  logic [FLAG_WIDTH-1:0]  i_special_flags,
  output logic [BIT_WIDTH-1:0]   o_result_c,
  output logic [FLAG_WIDTH-1:0]  o_flags_c
);

  localparam int unsigned EMAX = (32'd1 << EW) - 32'd1;

  logic                 w_inexact;
  logic                 w_inc;
  logic [MW:0]          w_sum;
  logic signed [EW+1:0] w_exp;
  logic                 w_ovf;
  logic                 w_unf;
  logic [BIT_WIDTH-1:0] w_inf;
  logic [BIT_WIDTH-1:0] w_max;

  always_comb begin
    w_inexact = i_guard | i_sticky;
    w_inc     = 1'b0;
    case (i_mode)
      RM_RNA:  w_inc = i_guard;
      RM_RTP:  w_inc = w_inexact & ~i_sign;
      RM_RTN:  w_inc = w_inexact & i_sign;
      RM_RTZ:  w_inc = 1'b0;
      default: w_inc = i_guard & (i_sticky | i_mant[0]);
    endcase
    // A carry out of the mantissa leaves it all-zero: just bump the exponent.
    w_sum = {1'b0, i_mant} + (MW+1)'(w_inc);
    w_exp = i_exp + $signed((EW+2)'(w_sum[MW]));
    w_ovf = (w_exp >= $signed((EW+2)'(EMAX)));
    w_unf = (w_exp < $signed((EW+2)'(1)));
    w_inf = {i_sign, {EW{1'b1}}, {MW{1'b0}}};
    w_max = {i_sign, {(EW-1){1'b1}}, 1'b0, {MW{1'b1}}};
  end

  always_comb begin
    o_result_c              = {i_sign, w_exp[EW-1:0], w_sum[MW-1:0]};
    o_flags_c               = '0;
    o_flags_c[FLAG_INEXACT] = w_inexact;
    if (i_special) begin
      o_result_c = i_special_val;
      o_flags_c  = i_special_flags;
    end else if (w_ovf) begin
      o_flags_c[FLAG_OVERFLOW] = 1'b1;
      o_flags_c[FLAG_INEXACT]  = 1'b1;
      case (i_mode)
        RM_RTZ:  o_result_c = w_max;
        RM_RTP:  o_result_c = i_sign ? w_max : w_inf;
        RM_RTN:  o_result_c = i_sign ? w_inf : w_max;
        default: o_result_c = w_inf;
      endcase
    end else if (w_unf) begin
      o_result_c                = {i_sign, {(BIT_WIDTH-1){1'b0}}};
      o_flags_c[FLAG_UNDERFLOW] = 1'b1;
      o_flags_c[FLAG_INEXACT]   = 1'b1;
    end
  end

endmodule

// File: rtl/fpu_mul_pipe.sv
// Three-stage IEEE-754 multiplier (DAZ/FTZ) with valid/ready handshake and
// a sideband tag; the whole pipe stalls together under output backpressure.
module fpu_mul_pipe
  import fpu_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = 32,
  parameter int unsigned TAG_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [2:0]            i_mode,
  input  logic [BIT_WIDTH-1:0]  i_inputA,
  input  logic [BIT_WIDTH-1:0]  i_inputB,
  input  logic [TAG_WIDTH-1:0]  i_tag,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [BIT_WIDTH-1:0]  o_output,
  output logic [TAG_WIDTH-1:0]  o_tag,
  output logic [3:0]            o_flags
);

  localparam int unsigned EW   = exp_width(BIT_WIDTH);
  localparam int unsigned SW   = sgn_width(BIT_WIDTH);
  localparam int unsigned MW   = SW - 1;
  localparam int unsigned PW   = 2 * SW;
  localparam int unsigned BIAS = exp_bias(BIT_WIDTH);
  localparam logic [BIT_WIDTH-1:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

  logic w_advance;

  // S1: unpack, classify, multiply significands
  logic [EW-1:0]        w_exp_a, w_exp_b;
  logic [MW-1:0]        w_man_a, w_man_b;
  logic                 w_zero_a, w_zero_b, w_inf_a, w_inf_b;
  logic                 w_nan_a, w_nan_b, w_snan_a, w_snan_b, w_inf_zero;
  logic                 w_sign;
  logic [PW-1:0]        w_prod;
  logic signed [EW+1:0] w_exp_sum;
  logic                 w_special;
  logic [BIT_WIDTH-1:0] w_special_val;
  logic [3:0]           w_special_flags;

  logic                 r_s1_valid, r_s1_sign, r_s1_special;
  logic signed [EW+1:0] r_s1_exp;
  logic [PW-1:0]        r_s1_prod;
  logic [2:0]           r_s1_mode;
  logic [TAG_WIDTH-1:0] r_s1_tag;
  logic [BIT_WIDTH-1:0] r_s1_special_val;
  logic [3:0]           r_s1_special_flags;

  logic [PW-2:0]        w_norm;

  logic                 r_s2_valid, r_s2_sign, r_s2_special;
  logic signed [EW+1:0] r_s2_exp;
  logic [MW-1:0]        r_s2_mant;
  logic                 r_s2_guard, r_s2_sticky;
  logic [2:0]           r_s2_mode;
  logic [TAG_WIDTH-1:0] r_s2_tag;
  logic [BIT_WIDTH-1:0] r_s2_special_val;
  logic [3:0]           r_s2_special_flags;

  logic [BIT_WIDTH-1:0] w_result_c;
  logic [3:0]           w_flags_c;

  assign w_advance = ~o_valid | i_ready;
  assign o_ready   = w_advance;

  always_comb begin
    w_exp_a    = i_inputA[BIT_WIDTH-2 -: EW];
    w_exp_b    = i_inputB[BIT_WIDTH-2 -: EW];
    w_man_a    = i_inputA[MW-1:0];
    w_man_b    = i_inputB[MW-1:0];
    // Subnormals classify as zero: exponent field alone decides.
    w_zero_a   = (w_exp_a == '0);
    w_zero_b   = (w_exp_b == '0);
    w_inf_a    = (&w_exp_a) & ~(|w_man_a);
    w_inf_b    = (&w_exp_b) & ~(|w_man_b);
    w_nan_a    = (&w_exp_a) & (|w_man_a);
    w_nan_b    = (&w_exp_b) & (|w_man_b);
    w_snan_a   = w_nan_a & ~w_man_a[MW-1];
    w_snan_b   = w_nan_b & ~w_man_b[MW-1];
    w_inf_zero = (w_inf_a & w_zero_b) | (w_zero_a & w_inf_b);
    w_sign     = i_inputA[BIT_WIDTH-1] ^ i_inputB[BIT_WIDTH-1];
    w_prod     = PW'({1'b1, w_man_a}) * PW'({1'b1, w_man_b});
    w_exp_sum  = (EW+2)'(w_exp_a) + (EW+2)'(w_exp_b) - (EW+2)'(BIAS);
  end

  always_comb begin
    w_special       = 1'b0;
    w_special_val   = '0;
    w_special_flags = '0;
    if (w_nan_a | w_nan_b | w_inf_zero) begin
      w_special                     = 1'b1;
      w_special_val                 = QNAN;
      w_special_flags[FLAG_INVALID] = w_snan_a | w_snan_b | w_inf_zero;
    end else if (w_inf_a | w_inf_b) begin
      w_special     = 1'b1;
      w_special_val = {w_sign, {EW{1'b1}}, {MW{1'b0}}};
    end else if (w_zero_a | w_zero_b) begin
      w_special     = 1'b1;
      w_special_val = {w_sign, {(BIT_WIDTH-1){1'b0}}};
    end
  end

  // S2: bring the leading one of the [1,4) product to the top bit
  assign w_norm = r_s1_prod[PW-1] ? r_s1_prod[PW-2:0] : {r_s1_prod[PW-3:0], 1'b0};

  fpu_round_pack #(.BIT_WIDTH(BIT_WIDTH)) u_round_pack (
    .i_sign          (r_s2_sign),
    .i_exp           (r_s2_exp),
    .i_mant          (r_s2_mant),
    .i_guard         (r_s2_guard),
    .i_sticky        (r_s2_sticky),
    .i_mode          (r_s2_mode),
    .i_special       (r_s2_special),
    .i_special_val   (r_s2_special_val),
    .i_special_flags (r_s2_special_flags),
    .o_result_c      (w_result_c),
    .o_flags_c       (w_flags_c)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      o_valid    <= 1'b0;
      o_output   <= '0;
      o_tag      <= '0;
      o_flags    <= '0;
    end else if (w_advance) begin
      r_s1_valid <= i_valid;
      r_s2_valid <= r_s1_valid;
      o_valid    <= r_s2_valid;
      o_output   <= w_result_c;
      o_tag      <= r_s2_tag;
      o_flags    <= w_flags_c;
    end
  end

  // Datapath registers: contents are don't-care while the matching valid is low
  always_ff @(posedge i_clk) begin
    if (w_advance) begin
      r_s1_sign          <= w_sign;
      r_s1_exp           <= w_exp_sum;
      r_s1_prod          <= w_prod;
      r_s1_mode          <= i_mode;
      r_s1_tag           <= i_tag;
      r_s1_special       <= w_special;
      r_s1_special_val   <= w_special_val;
      r_s1_special_flags <= w_special_flags;
      r_s2_sign          <= r_s1_sign;
      r_s2_exp           <= r_s1_exp + $signed((EW+2)'(r_s1_prod[PW-1]));
      r_s2_mant          <= w_norm[PW-2 -: MW];
      r_s2_guard         <= w_norm[PW-2-MW];
      r_s2_sticky        <= |w_norm[PW-3-MW:0];
      r_s2_mode          <= r_s1_mode;
      r_s2_tag           <= r_s1_tag;
      r_s2_special       <= r_s1_special;
      r_s2_special_val   <= r_s1_special_val;
      r_s2_special_flags <= r_s1_special_flags;
    end
  end

endmodule

// File: tb/tb_fpu_mul_pipe.sv
// Bench for fpu_mul_pipe: directed vectors, expected results queued at issue
// and retired in order as the 32-bit DUT delivers them; one 64-bit instance.
module tb_fpu_mul_pipe;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  tag;
    logic [3:0]  flg;
  } exp32_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid32, o_ready32, o_valid32, out_ready32;
  logic [2:0]  in_mode32;
  logic [31:0] in_a32, in_b32, o_output32;
  logic [3:0]  in_tag32, o_tag32, o_flags32;

  logic        in_valid64, o_ready64, o_valid64, out_ready64;
  logic [2:0]  in_mode64;
  logic [63:0] in_a64, in_b64, o_output64;
  logic [3:0]  in_tag64, o_tag64, o_flags64;

  int     n_chk = 0;
  int     n_err = 0;
  exp32_t q32[$];
  exp32_t mon_e;
  int     issued;
  logic   xfer;

  logic [31:0] bp_a [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                            32'hC0000000, 32'h3F000000, 32'h3FC00000};
  logic [31:0] bp_b [6] = '{32'h40000000, 32'h40400000, 32'h40400000,
                            32'h40400000, 32'h3F000000, 32'h3FC00000};
  logic [31:0] bp_r [6] = '{32'h40000000, 32'h40C00000, 32'h41100000,
                            32'hC0C00000, 32'h3E800000, 32'h40100000};

  fpu_mul_pipe #(.BIT_WIDTH(32), .TAG_WIDTH(4)) u_dut32 (
    .i_clk(clk), .i_reset(rst), .i_valid(in_valid32), .o_ready(o_ready32),
    .i_mode(in_mode32), .i_inputA(in_a32), .i_inputB(in_b32), .i_tag(in_tag32),
    .o_valid(o_valid32), .i_ready(out_ready32), .o_output(o_output32),
    .o_tag(o_tag32), .o_flags(o_flags32)
  );

  fpu_mul_pipe #(.BIT_WIDTH(64), .TAG_WIDTH(4)) u_dut64 (
    .i_clk(clk), .i_reset(rst), .i_valid(in_valid64), .o_ready(o_ready64),
    .i_mode(in_mode64), .i_inputA(in_a64), .i_inputB(in_b64), .i_tag(in_tag64),
    .o_valid(o_valid64), .i_ready(out_ready64), .o_output(o_output64),
    .o_tag(o_tag64), .o_flags(o_flags64)
  );

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, expv);
    end
  endtask

  task automatic issue32(input logic [31:0] a, input logic [31:0] b, input logic [2:0] mode,
                         input logic [3:0] tag, input logic [31:0] res, input logic [3:0] flg);
    int budget;
    budget     = 0;
    in_valid32 = 1'b1;
    in_a32     = a;
    in_b32     = b;
    in_mode32  = mode;
    in_tag32   = tag;
    @(negedge clk);
    while (!o_ready32 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    check("issue_ready", 64'(o_ready32), 64'(1));
    @(posedge clk);
    if (o_ready32) q32.push_back('{res: res, tag: tag, flg: flg});
    #1 in_valid32 = 1'b0;
  endtask

  task automatic drain32();
    for (int i = 0; i < 50 && q32.size() > 0; i++) @(posedge clk);
    check("drain_empty", 64'(q32.size()), 64'(0));
    #1;
  endtask

  // Retire expected results in order; a stalled output must keep showing the head entry
  always @(negedge clk) begin
    if (!rst && o_valid32) begin
      check("output_expected", 64'(q32.size() != 0), 64'(1));
      if (q32.size() != 0) begin
        mon_e = out_ready32 ? q32.pop_front() : q32[0];
        check("result", 64'(o_output32), 64'(mon_e.res));
        check("tag",    64'(o_tag32),    64'(mon_e.tag));
        check("flags",  64'(o_flags32),  64'(mon_e.flg));
      end
    end
  end

  initial begin
    rst = 1'b1;
    in_valid32 = 1'b0; in_mode32 = '0; in_a32 = '0; in_b32 = '0; in_tag32 = '0;
    in_valid64 = 1'b0; in_mode64 = '0; in_a64 = '0; in_b64 = '0; in_tag64 = '0;
    out_ready32 = 1'b1; out_ready64 = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid",  64'(o_valid32),  64'(0));
    check("rst_output", 64'(o_output32), 64'(0));
    check("rst_tag",    64'(o_tag32),    64'(0));
    check("rst_flags",  64'(o_flags32),  64'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready32", 64'(o_ready32), 64'(1));
    check("post_rst_ready64", 64'(o_ready64), 64'(1));
    @(posedge clk);
    #1;

    // Basic product with exact 3-cycle latency
    in_valid32 = 1'b1; in_a32 = 32'h40000000; in_b32 = 32'h40400000;
    in_mode32 = 3'd0; in_tag32 = 4'd5;
    @(negedge clk);
    check("lat_ready", 64'(o_ready32), 64'(1));
    @(posedge clk);
    q32.push_back('{res: 32'h40C00000, tag: 4'd5, flg: 4'b0000});
    #1 in_valid32 = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("lat_valid_c%0d", k), 64'(o_valid32), 64'(k == 3));
    end
    drain32();

    // Rounding modes, carry-out renormalisation, ties
    issue32(32'h3F800001, 32'h3F800001, 3'd0, 4'd1, 32'h3F800002, 4'b0001);
    issue32(32'h3F800001, 32'h3F800001, 3'd4, 4'd2, 32'h3F800002, 4'b0001);
    issue32(32'h3F800001, 32'h3F800001, 3'd2, 4'd3, 32'h3F800003, 4'b0001);
    issue32(32'h3F800001, 32'h3F800001, 3'd7, 4'd4, 32'h3F800002, 4'b0001);
    issue32(32'h3F800001, 32'h3F800001, 3'd3, 4'd5, 32'h3F800002, 4'b0001);
    issue32(32'hBF800001, 32'h3F800001, 3'd3, 4'd6, 32'hBF800003, 4'b0001);
    issue32(32'hBF800001, 32'h3F800001, 3'd2, 4'd7, 32'hBF800002, 4'b0001);
    issue32(32'h3F800001, 32'h3FFFFFFE, 3'd0, 4'd8, 32'h40000000, 4'b0001);
    issue32(32'h3F800001, 32'h3FFFFFFE, 3'd4, 4'd9, 32'h3FFFFFFF, 4'b0001);
    issue32(32'h3F800003, 32'h3FC00000, 3'd0, 4'd10, 32'h3FC00004, 4'b0001);
    issue32(32'h3F800003, 32'h3FC00000, 3'd1, 4'd11, 32'h3FC00005, 4'b0001);
    drain32();

    // Overflow per mode and sign, specials
    issue32(32'h7F000000, 32'h7F000000, 3'd0, 4'd1, 32'h7F800000, 4'b0101);
    issue32(32'h7F000000, 32'h7F000000, 3'd4, 4'd2, 32'h7F7FFFFF, 4'b0101);
    issue32(32'h7F000000, 32'h7F000000, 3'd1, 4'd3, 32'h7F800000, 4'b0101);
    issue32(32'h7F000000, 32'h7F000000, 3'd2, 4'd4, 32'h7F800000, 4'b0101);
    issue32(32'h7F000000, 32'h7F000000, 3'd3, 4'd5, 32'h7F7FFFFF, 4'b0101);
    issue32(32'hFF000000, 32'h7F000000, 3'd2, 4'd6, 32'hFF7FFFFF, 4'b0101);
    issue32(32'hFF000000, 32'h7F000000, 3'd3, 4'd7, 32'hFF800000, 4'b0101);
    issue32(32'h7F800000, 32'h00000000, 3'd0, 4'd8, 32'h7FC00000, 4'b1000);
    issue32(32'h00000000, 32'hFF800000, 3'd0, 4'd9, 32'h7FC00000, 4'b1000);
    issue32(32'h7F800001, 32'h3F800000, 3'd0, 4'd10, 32'h7FC00000, 4'b1000);
    issue32(32'hFFC00001, 32'h3F800000, 3'd0, 4'd11, 32'h7FC00000, 4'b0000);
    issue32(32'h7F800000, 32'hC0000000, 3'd0, 4'd12, 32'hFF800000, 4'b0000);
    issue32(32'h00000000, 32'hC0400000, 3'd0, 4'd13, 32'h80000000, 4'b0000);
    drain32();

    // Underflow flush and DAZ
    issue32(32'h00800000, 32'h3F000000, 3'd0, 4'd1, 32'h00000000, 4'b0011);
    issue32(32'h80800000, 32'h3F000000, 3'd0, 4'd2, 32'h80000000, 4'b0011);
    issue32(32'h00000001, 32'h40000000, 3'd0, 4'd3, 32'h00000000, 4'b0000);
    issue32(32'h00000001, 32'h7F800000, 3'd0, 4'd4, 32'h7FC00000, 4'b1000);
    drain32();

    // Back-to-back issue with a 5-cycle output stall
    issued = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (issued == 6 && q32.size() == 0) break;
      out_ready32 = !(cyc >= 4 && cyc <= 8);
      in_valid32  = (issued < 6);
      if (issued < 6) begin
        in_a32    = bp_a[issued];
        in_b32    = bp_b[issued];
        in_tag32  = 4'(10 + issued);
        in_mode32 = 3'd0;
      end
      @(negedge clk);
      if (cyc >= 4 && cyc <= 8) check("bp_ready_low", 64'(o_ready32), 64'(0));
      xfer = in_valid32 && o_ready32;
      @(posedge clk);
      if (xfer) begin
        q32.push_back('{res: bp_r[issued], tag: 4'(10 + issued), flg: 4'b0000});
        issued++;
      end
      #1;
    end
    in_valid32  = 1'b0;
    out_ready32 = 1'b1;
    check("bp_issued",  64'(issued),     64'(6));
    check("bp_drained", 64'(q32.size()), 64'(0));

    // Reset with three operations in flight
    in_valid32 = 1'b1; in_mode32 = 3'd0;
    in_a32 = 32'h3F800000; in_b32 = 32'h40000000; in_tag32 = 4'd1;
    @(posedge clk);
    #1 in_a32 = 32'h40000000; in_b32 = 32'h40400000; in_tag32 = 4'd2;
    @(posedge clk);
    #1 in_a32 = 32'h40400000; in_b32 = 32'h40400000; in_tag32 = 4'd3;
    @(posedge clk);
    #1 rst = 1'b1; in_valid32 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrst_valid",  64'(o_valid32),  64'(0));
    check("midrst_output", 64'(o_output32), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_ready", 64'(o_ready32), 64'(1));
    for (int k = 0; k < 8; k++) begin
      check("no_stale", 64'(o_valid32), 64'(0));
      @(negedge clk);
    end
    @(posedge clk);
    #1;

    // 64-bit instance: same product, same latency
    in_valid64 = 1'b1; in_a64 = 64'h4000000000000000; in_b64 = 64'h4008000000000000;
    in_mode64 = 3'd0; in_tag64 = 4'd5;
    @(negedge clk);
    check("d64_ready", 64'(o_ready64), 64'(1));
    @(posedge clk);
    #1 in_valid64 = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("d64_valid_c%0d", k), 64'(o_valid64), 64'(k == 3));
    end
    check("d64_result", o_output64,       64'h4018000000000000);
    check("d64_tag",    64'(o_tag64),     64'(5));
    check("d64_flags",  64'(o_flags64),   64'(0));
    @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
